// File: rtl/ppfifo_pkg.sv
// Shared types and constants for the single-clock ping-pong FIFO.
// Holds the bank state encoding and the sizing helpers used by the top and the banks.
package ppfifo_pkg;

  typedef enum logic [1:0] {
    StEmpty,
    StWriting,
    StFull,
    StReading
  } bank_state_e;

  localparam int unsigned DefaultAddressWidth = 8;
  localparam int unsigned BANK_DEPTH = 32'd1 << DefaultAddressWidth;
  localparam int unsigned SIZE_WIDTH = 24;

  function automatic int unsigned bank_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ppfifo_bank.sv
// One ping-pong bank: storage, EMPTY/WRITING/FULL/READING state, write count and
// a registered read port whose address looks ahead to the post-strobe pointer.
module ppfifo_bank
  import ppfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_activate,
  input  logic                    wr_allow,
  input  logic                    wr_strobe,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_start,
  input  logic                    rd_release,
  input  logic                    rd_strobe,
  output logic                    wr_ready,
  output logic                    commit,
  output logic [ADDRESS_WIDTH:0]  count,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int unsigned BankDepth = bank_depth(ADDRESS_WIDTH);
  localparam logic [ADDRESS_WIDTH:0] CountFull = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [BankDepth];

  bank_state_e state_q, state_d;
  logic [ADDRESS_WIDTH:0] count_q, count_d;
  logic [ADDRESS_WIDTH:0] rptr_q, rptr_d;
  logic wr_ready_q, wr_ready_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic we, rd_en;

  // The write pointer is the low bits of the count, so no separate register is kept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    we      = 1'b0;
    rd_en   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (wr_activate && wr_allow && wr_ready_q) begin
          state_d = StWriting;
          count_d = '0;
        end
      end
      StWriting: begin
        if (!wr_activate) begin
          if (count_q != '0) begin
            state_d = StFull;
            commit  = 1'b1;
          end else begin
            state_d = StEmpty;
          end
        end else if (wr_strobe && (count_q != CountFull)) begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      StFull: begin
        if (rd_start) begin
          state_d = StReading;
          rptr_d  = '0;
          rd_en   = 1'b1;
        end
      end
      StReading: begin
        if (rd_release) begin
          state_d = StEmpty;
        end else if (rd_strobe && (rptr_q != count_q)) begin
          rptr_d = rptr_q + 1'b1;
          // Past the last word the output register holds its value.
          rd_en  = (rptr_d != count_q);
        end
      end
      default: state_d = StEmpty;
    endcase
    wr_ready_d = (state_d == StEmpty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StEmpty;
      count_q    <= '0;
      rptr_q     <= '0;
      wr_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      wr_ready_q <= wr_ready_d;
      if (rd_en) begin
        rd_data_q <= mem[rptr_d[ADDRESS_WIDTH-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[count_q[ADDRESS_WIDTH-1:0]] <= wr_data;
    end
  end

  assign wr_ready = wr_ready_q;
  assign count    = count_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/ppfifo_single_clk.sv
// Single-clock ping-pong FIFO top: two banks, a two-entry commit queue that fixes the
// read order, and the read-side offer/mux logic.
module ppfifo_single_clk
  import ppfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [1:0]            write_ready,
  input  logic [1:0]            write_activate,
  output logic [SIZE_WIDTH-1:0] write_fifo_size,
  input  logic                  write_strobe,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  read_ready,
  input  logic                  read_activate,
  output logic [SIZE_WIDTH-1:0] read_count,
  input  logic                  read_strobe,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int unsigned BankDepth = bank_depth(ADDRESS_WIDTH);
  localparam int unsigned CntW      = ADDRESS_WIDTH + 1;

  logic [1:0] bank_ready, bank_commit;
  logic [1:0] rd_start, rd_release, rd_strobe_b;
  logic [CntW-1:0] bank_count [2];
  logic [DATA_WIDTH-1:0] bank_rdata [2];
  logic wr_allow;

  // Commit queue: q0 is the head (oldest committed bank).
  logic q0_q, q0_d, q1_q, q1_d;
  logic [1:0] qcnt_q, qcnt_d;
  logic rd_active_q, rd_active_d;
  logic rd_bank_q, rd_bank_d;
  logic read_ready_q, read_ready_d;
  logic [CntW-1:0] read_count_q, read_count_d;
  logic push, push_idx, pop, release_rd;

  assign wr_allow = (write_activate != 2'b11);

  for (genvar i = 0; i < 2; i++) begin : g_bank
    ppfifo_bank #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_activate(write_activate[i]),
      .wr_allow   (wr_allow),
      .wr_strobe  (write_strobe),
      .wr_data    (write_data),
      .rd_start   (rd_start[i]),
      .rd_release (rd_release[i]),
      .rd_strobe  (rd_strobe_b[i]),
      .wr_ready   (bank_ready[i]),
      .commit     (bank_commit[i]),
      .count      (bank_count[i]),
      .rd_data    (bank_rdata[i])
    );
  end

  // Only one bank can be WRITING at a time, so at most one commit per cycle.
  assign push       = |bank_commit;
  assign push_idx   = bank_commit[1];
  assign pop        = read_activate && read_ready_q;
  assign release_rd = rd_active_q && !read_activate;

  always_comb begin
    q0_d   = q0_q;
    q1_d   = q1_q;
    qcnt_d = qcnt_q;
    if (pop) begin
      q0_d   = q1_q;
      qcnt_d = qcnt_q - 2'd1;
    end
    if (push) begin
      if (qcnt_d == 2'd0) begin
        q0_d = push_idx;
      end else begin
        q1_d = push_idx;
      end
      qcnt_d = qcnt_d + 2'd1;
    end

    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    if (pop) begin
      rd_active_d = 1'b1;
      rd_bank_d   = q0_q;
    end else if (release_rd) begin
      rd_active_d = 1'b0;
    end

    read_ready_d = (qcnt_d != 2'd0) && !read_activate;

    read_count_d = '0;
    if (rd_active_d) begin
      read_count_d = bank_count[rd_bank_d];
    end else if (qcnt_d != 2'd0) begin
      read_count_d = bank_count[q0_d];
    end

    rd_start    = '0;
    rd_release  = '0;
    rd_strobe_b = '0;
    if (pop) begin
      rd_start[q0_q] = 1'b1;
    end
    if (release_rd) begin
      rd_release[rd_bank_q] = 1'b1;
    end
    if (rd_active_q) begin
      rd_strobe_b[rd_bank_q] = read_strobe;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q0_q         <= 1'b0;
      q1_q         <= 1'b0;
      qcnt_q       <= 2'd0;
      rd_active_q  <= 1'b0;
      rd_bank_q    <= 1'b0;
      read_ready_q <= 1'b0;
      read_count_q <= '0;
    end else begin
      q0_q         <= q0_d;
      q1_q         <= q1_d;
      qcnt_q       <= qcnt_d;
      rd_active_q  <= rd_active_d;
      rd_bank_q    <= rd_bank_d;
      read_ready_q <= read_ready_d;
      read_count_q <= read_count_d;
    end
  end

  assign write_ready     = bank_ready;
  assign write_fifo_size = SIZE_WIDTH'(BankDepth);
  assign read_ready      = read_ready_q;
  assign read_count      = SIZE_WIDTH'(read_count_q);
  assign read_data       = bank_rdata[rd_bank_q];

endmodule

// File: tb/tb_ppfifo_single_clk.sv
// Randomized bench for ppfifo_single_clk against a burst-level model built from
// per-bank word queues and a commit-order queue of bank indices.
module tb_ppfifo_single_clk;

  localparam int Depth = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  write_ready;
  logic [1:0]  write_activate;
  logic [23:0] write_fifo_size;
  logic        write_strobe;
  logic [31:0] write_data;
  logic        read_ready;
  logic        read_activate;
  logic [23:0] read_count;
  logic        read_strobe;
  logic [31:0] read_data;

  always #5 clk = ~clk;

  ppfifo_single_clk #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .write_ready    (write_ready),
    .write_activate (write_activate),
    .write_fifo_size(write_fifo_size),
    .write_strobe   (write_strobe),
    .write_data     (write_data),
    .read_ready     (read_ready),
    .read_activate  (read_activate),
    .read_count     (read_count),
    .read_strobe    (read_strobe),
    .read_data      (read_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: words held by each bank, banks in commit order, bank free for the producer.
  logic [31:0] bd [2][$];
  int          cq [$];
  bit          rdy [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ready();
    return {rdy[1], rdy[0]};
  endfunction

  task automatic check_offer(input string tag);
    check_val({tag, "_write_ready"}, 32'(write_ready), 32'(exp_ready()));
    check_val({tag, "_read_ready"}, 32'(read_ready), 32'(cq.size() > 0));
    if (cq.size() > 0) begin
      check_val({tag, "_read_count"}, 32'(read_count), 32'(bd[cq[0]].size()));
    end
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    write_activate = 2'b00;
    write_strobe   = 1'b0;
    write_data     = '0;
    read_activate  = 1'b0;
    read_strobe    = 1'b0;
    tick();
    check_val("rst_write_ready", 32'(write_ready), 32'd0);
    check_val("rst_read_ready", 32'(read_ready), 32'd0);
    check_val("rst_read_count", 32'(read_count), 32'd0);
    check_val("rst_read_data", read_data, 32'd0);
    check_val("rst_fifo_size", 32'(write_fifo_size), 32'(Depth));
    tick();
    rst = 1'b1;
    tick();
    cq.delete();
    bd[0].delete();
    bd[1].delete();
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    check_val("post_rst_write_ready", 32'(write_ready), 32'd3);
    check_val("post_rst_read_ready", 32'(read_ready), 32'd0);
    check_val("post_rst_read_count", 32'(read_count), 32'd0);
  endtask

  // Burst of n strobes into bank b; seq selects data = index instead of random.
  task automatic do_write(input int b, input int n, input bit seq, input int gap_max);
    int g;
    write_activate = 2'(1 << b);
    tick();
    rdy[b] = 1'b0;
    check_val("claim_write_ready", 32'(write_ready), 32'(exp_ready()));
    for (int i = 0; i < n; i++) begin
      write_strobe = 1'b1;
      write_data   = seq ? 32'(i) : $urandom();
      if (i < Depth) bd[b].push_back(write_data);
      tick();
      if (gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        write_strobe = 1'b0;
        repeat (g) tick();
      end
    end
    write_strobe   = 1'b0;
    write_activate = 2'b00;
    tick();
    if (n > 0) cq.push_back(b);
    else rdy[b] = 1'b1;
    check_offer("commit");
  endtask

  // Reads the head bank; nread < 0 reads everything and then strobes past the end.
  task automatic do_read(input int nread);
    int b, n, m;
    b = cq[0];
    n = bd[b].size();
    check_val("offer_read_ready", 32'(read_ready), 32'd1);
    check_val("offer_read_count", 32'(read_count), 32'(n));
    read_activate = 1'b1;
    tick();
    void'(cq.pop_front());
    check_val("act_read_ready", 32'(read_ready), 32'd0);
    check_val("act_read_count", 32'(read_count), 32'(n));
    m = (nread < 0 || nread > n) ? n : nread;
    for (int k = 0; k < m; k++) begin
      check_val($sformatf("read_data[%0d]", k), read_data, bd[b][k]);
      read_strobe = 1'b1;
      tick();
      read_strobe = 1'b0;
      if ($urandom_range(3, 0) == 0) tick();
    end
    if (nread < 0) begin
      repeat (2) begin
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        check_val("read_hold", read_data, bd[b][n-1]);
      end
      check_val("read_count_hold", 32'(read_count), 32'(n));
    end
    read_activate = 1'b0;
    tick();
    bd[b].delete();
    rdy[b] = 1'b1;
    check_offer("release");
  endtask

  initial begin
    int r, b, n;

    do_reset();

    // Basic burst of 0..9 through bank 0.
    do_write(0, 10, 1'b1, 0);
    do_read(-1);

    // Commit order: bank 0 (5 words) then bank 1 (3 words).
    do_write(0, 5, 1'b0, 1);
    do_write(1, 3, 1'b0, 1);
    do_read(-1);
    do_read(-1);

    // Overflow: only the first 256 of 300 strobes are kept.
    do_write(0, 300, 1'b1, 0);
    check_val("overflow_count", 32'(read_count), 32'd256);
    do_read(-1);

    // Empty commit and illegal dual activate.
    do_write(1, 0, 1'b0, 0);
    write_activate = 2'b11;
    tick();
    check_val("dual_act_write_ready", 32'(write_ready), 32'd3);
    check_val("dual_act_read_ready", 32'(read_ready), 32'd0);
    write_activate = 2'b00;
    tick();
    check_val("dual_act_after", 32'(write_ready), 32'd3);

    // Bank 1 commits in the same cycle that bank 0 is released.
    do_write(0, 6, 1'b0, 0);
    read_activate = 1'b1;
    tick();
    void'(cq.pop_front());
    check_val("sim_read_count", 32'(read_count), 32'd6);
    check_val("sim_read_data0", read_data, bd[0][0]);
    write_activate = 2'b10;
    tick();
    rdy[1] = 1'b0;
    check_val("sim_claim_ready", 32'(write_ready), 32'(exp_ready()));
    for (int i = 0; i < 3; i++) begin
      write_strobe = 1'b1;
      write_data   = $urandom();
      bd[1].push_back(write_data);
      read_strobe  = (i < 2);
      tick();
    end
    check_val("sim_read_data2", read_data, bd[0][2]);
    write_strobe   = 1'b0;
    read_strobe    = 1'b0;
    write_activate = 2'b00;
    read_activate  = 1'b0;
    tick();
    bd[0].delete();
    rdy[0] = 1'b1;
    cq.push_back(1);
    check_offer("sim");
    do_read(-1);

    // Randomized mix of bursts, partial reads and full reads.
    repeat (40) begin
      r = $urandom_range(3, 0);
      if (cq.size() == 0 || (r < 2 && (rdy[0] || rdy[1]))) begin
        if (rdy[0] && rdy[1]) b = $urandom_range(1, 0);
        else b = rdy[0] ? 0 : 1;
        do_write(b, $urandom_range(20, 0), 1'b0, 2);
      end else if (r == 2) begin
        n = bd[cq[0]].size();
        do_read($urandom_range(n, 0));
      end else begin
        do_read(-1);
      end
    end
    while (cq.size() > 0) do_read(-1);

    // Reset with bank 1 full and bank 0 mid-burst.
    do_write(1, 4, 1'b0, 0);
    write_activate = 2'b01;
    tick();
    for (int i = 0; i < 4; i++) begin
      write_strobe = 1'b1;
      write_data   = $urandom();
      tick();
    end
    do_reset();
    repeat (3) tick();
    check_val("no_stale_read_ready", 32'(read_ready), 32'd0);
    do_write(0, 2, 1'b1, 0);
    do_read(-1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ppfifo_single_clk.md
Name: ppfifo_single_clk

Overview:
- Single-clock ping-pong FIFO that sits directly downstream of the test stimulus writer and other burst producers.
- Two equal banks: the producer fills one bank while the consumer drains the other.
- Write side uses the ready/activate/size/strobe/data burst handshake. The read side mirrors it with a single activate bit.
- Used in simulation benches and as the buffering stage between burst producers and the transport layer.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- ADDRESS_WIDTH, 8, log2 of words per bank (default depth 256).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-low.
- write_ready  output  2  bit i = bank i empty and available to the producer.
- write_activate  input  2  one-hot; producer claims bank i for the duration of its burst.
- write_fifo_size  output  24  words per bank, constant 2^ADDRESS_WIDTH.
- write_strobe  input  1  store write_data into the active bank this cycle.
- write_data  input  DATA_WIDTH  word to store.
- read_ready  output  1  a committed bank is waiting and the consumer is idle.
- read_activate  input  1  consumer claims the oldest committed bank.
- read_count  output  24  word count of the offered/active bank.
- read_strobe  input  1  consume the current read_data word.
- read_data  output  DATA_WIDTH  current word of the active read bank.

Behaviour:
- Reset (rst low at a clk edge):
  - Both banks go to EMPTY; the commit queue is cleared; all pointers and counts are 0.
  - write_ready=0, read_ready=0, read_count=0, read_data=0.
  - write_fifo_size is constant and holds its value during reset.
  - write_ready=2'b11 on the first edge after rst goes high.
  - Reset mid-burst discards all stored data.
- Per-bank state machine: EMPTY -> WRITING -> FULL -> READING -> EMPTY.
- EMPTY -> WRITING:
  - Taken on write_activate[i]=1 while write_ready[i]=1.
  - write_ready[i] clears the same edge; the write pointer and count reset to 0.
- WRITING:
  - Each write_strobe stores write_data at the write pointer and increments the count.
  - Strobes with count == 2^ADDRESS_WIDTH are dropped; no wrap.
  - Strobes with write_activate == 0 are ignored.
- WRITING -> FULL or EMPTY, on write_activate[i] falling:
  - count > 0: the bank goes to FULL and is pushed onto a 2-entry commit queue.
  - count == 0: the bank returns to EMPTY, and write_ready[i] reasserts the next edge.
- Illegal write_activate values:
  - write_activate == 2'b11: ignored; no bank is claimed.
  - Activating a non-ready bank: ignored.
- Read offer:
  - read_ready=1 when the queue is non-empty and read_activate=0.
  - read_count shows the head bank's count, registered and valid while read_ready or read_activate is high.
- FULL -> READING:
  - Taken on read_activate rising while read_ready=1; the head bank pops, read_ready clears, and the read pointer resets to 0.
  - Banks are read in commit order, not bank-index order.
- read_data timing:
  - read_data is a registered memory read. Word 0 is valid 1 cycle after read_activate is first seen high.
  - Each read_strobe advances the pointer; the next word is valid the following cycle.
  - Strobes beyond read_count are ignored; read_data holds its value.
- READING -> EMPTY:
  - Taken on read_activate falling; unread words are discarded.
  - write_ready[i] reasserts the next edge.
- Simultaneous events:
  - A write commit and a read release in the same cycle are both applied.
  - A commit into an empty queue while the consumer is idle raises read_ready the next edge.
  - Latency from producer commit to read_ready is 1 cycle.
- Widths: counts are ADDRESS_WIDTH+1 bits internally, zero-extended to 24 on the ports.

Decomposition:
- Package ppfifo_pkg holds:
  - bank state encoding (EMPTY, WRITING, FULL, READING);
  - localparam BANK_DEPTH = 2**ADDRESS_WIDTH;
  - the 24-bit size width constant.
- Sub-module ppfifo_bank, instantiated twice, contains:
  - one bank memory plus its state register;
  - write pointer/count and read pointer;
  - a registered read port.
- The top level holds the commit queue and the read-side mux.

Test Plan:
- Reset release with idle inputs -> write_ready=2'b11 one cycle later, read_ready=0, write_fifo_size=256.
- Write 10 words (0..9) into bank 0, then release -> read_ready=1 next cycle, read_count=10. Activate and strobe 10 times -> read_data sequence 0..9. Release -> write_ready[0]=1 next cycle.
- Ordering: fill bank 0 with 5 words (A0..A4), then bank 1 with 3 words (B0..B2), reader idle -> first read burst has read_count=5, data A0..A4; second has read_count=3, data B0..B2.
- Overflow: 300 strobes of values 0..299 into one bank -> read_count=256, data 0..255, values 256..299 never appear.
- Empty commit: activate bank 1, release with no strobes -> write_ready[1] reasserts next edge, read_ready stays 0. Also write_activate=2'b11 -> write_ready unchanged.
- Reset mid-operation: rst low after 4 strobes into bank 0 and with bank 1 FULL -> all outputs 0 during reset. After release, write_ready=2'b11, read_ready=0, no stale data offered.
